// File: rtl/cmp_serial_pkg.sv
// Shared encodings for the serial comparator and the GCD control path.
package cmp_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    localparam int RES_EQ = 0;
    localparam int RES_LT = 1;
    localparam int RES_GT = 2;
    localparam int RES_W  = 3;

    typedef logic [RES_W-1:0] cmp_res_t;

    localparam cmp_res_t RES_NONE = '0;

endpackage

// File: rtl/cmp_slice.sv
// Combinational magnitude compare of one slice; flip_msb biases a signed top slice.
module cmp_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    logic [CHUNK-1:0] msk;
    logic [CHUNK-1:0] ab;
    logic [CHUNK-1:0] bb;

    always_comb begin
        msk = '0;
        msk[CHUNK-1] = flip_msb;
        ab = a ^ msk;
        bb = b ^ msk;
        eq = (ab == bb);
        lt = (ab < bb);
        gt = (ab > bb);
    end

endmodule

// File: rtl/cmp_serial.sv
// Multi-cycle X/Y magnitude compare, MSB slice first, early exit on first difference.
module cmp_serial
    import cmp_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             eq_out,
    output logic             lt_out,
    output logic             gt_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("cmp_serial: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    cmp_state_e       state;
    cmp_state_e       state_nx;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             sgn;
    logic [IDXW-1:0]  idx;
    cmp_res_t         res;

    logic [WIDTH-1:0] xsh;
    logic [WIDTH-1:0] ysh;
    logic             s_eq;
    logic             s_lt;
    logic             s_gt;
    logic             accept;
    logic             last;

    assign accept = (state == ST_IDLE) && start && !abort;
    assign last = (idx == '0);
    assign xsh = xr >> (CHUNK * int'(idx));
    assign ysh = yr >> (CHUNK * int'(idx));

    cmp_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a       (xsh[CHUNK-1:0]),
        .b       (ysh[CHUNK-1:0]),
        .flip_msb(sgn && (idx == IDX_TOP)),
        .eq      (s_eq),
        .lt      (s_lt),
        .gt      (s_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_COMP;
            ST_COMP: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!s_eq || last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_COMP);
        done = (state == ST_DONE);
        eq_out = res[RES_EQ];
        lt_out = res[RES_LT];
        gt_out = res[RES_GT];
    end

    // Abort outranks any slice decision made in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr  <= '0;
            yr  <= '0;
            sgn <= 1'b0;
            idx <= '0;
            res <= RES_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        xr  <= X;
                        yr  <= Y;
                        sgn <= signed_mode;
                        idx <= IDX_TOP;
                        res <= RES_NONE;
                    end
                end
                ST_COMP: begin
                    if (abort) begin
                        res <= RES_NONE;
                    end else if (!s_eq) begin
                        res[RES_LT] <= s_lt;
                        res[RES_GT] <= s_gt;
                    end else if (last) begin
                        res[RES_EQ] <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (abort) res <= RES_NONE;
                end
                default: res <= RES_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Directed checks of cmp_serial: 32/8 instance plus a single-slice 8/8 instance.
module tb_cmp_serial;

    localparam logic [2:0] R0 = 3'b000;
    localparam logic [2:0] EQ = 3'b001;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] GT = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic        busy, done, eq_out, lt_out, gt_out;

    logic        start_b = 1'b0;
    logic        sgn_b = 1'b0;
    logic [7:0]  xb = '0;
    logic [7:0]  yb = '0;
    logic        busy_b, done_b, eq_b, lt_b, gt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmp_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .signed_mode(signed_mode), .X(X), .Y(Y),
        .busy(busy), .done(done),
        .eq_out(eq_out), .lt_out(lt_out), .gt_out(gt_out)
    );

    cmp_serial #(.WIDTH(8), .CHUNK(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
        .signed_mode(sgn_b), .X(xb), .Y(yb),
        .busy(busy_b), .done(done_b),
        .eq_out(eq_b), .lt_out(lt_b), .gt_out(gt_b)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [2:0]  res;
        int          m;
    } vec_t;

    vec_t vt[9];

    function automatic logic [2:0] res_a();
        return {gt_out, lt_out, eq_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Starts a compare at the next edge (E0), returns slices taken and result.
    task automatic run(input logic [31:0] x, input logic [31:0] y,
                       input logic s, output int m, output int bcnt,
                       output logic [2:0] res);
        @(negedge clk);
        X = x; Y = y; signed_mode = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = 0;
        bcnt = busy ? 1 : 0;
        while (!done && m < 8) begin
            @(posedge clk); #1;
            m++;
            if (busy) bcnt++;
        end
        res = res_a();
    endtask

    initial begin
        int m, bc;
        logic [2:0] r;

        vt[0] = '{32'h12345678, 32'h12345678, 1'b0, EQ, 4};
        vt[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, GT, 1};
        vt[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, LT, 1};
        vt[3] = '{32'h000000FE, 32'h000000FF, 1'b0, LT, 4};
        vt[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, LT, 1};
        vt[5] = '{32'h12345678, 32'h12335678, 1'b0, GT, 2};
        vt[6] = '{32'h80000000, 32'h80000001, 1'b1, LT, 4};
        vt[7] = '{32'h7F00FF00, 32'h7F00FE00, 1'b1, GT, 3};
        vt[8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, LT, 4};

        #12;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_res", 32'(res_a()), 32'(R0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run(vt[i].x, vt[i].y, vt[i].s, m, bc, r);
            chk($sformatf("v%0d_res", i), 32'(r), 32'(vt[i].res));
            chk($sformatf("v%0d_lat", i), 32'(m), 32'(vt[i].m));
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'(vt[i].m));
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", i), 32'({busy, done}), 0);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_hold", i), 32'(res_a()), 32'(vt[i].res));
        end

        // start pulsed mid-compare must not re-latch operands
        @(negedge clk);
        X = 32'hAAAAAAAA; Y = 32'hAAAAAAAA; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        X = 32'hFFFFFFFF; Y = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy", 32'(busy), 1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("ign_done", 32'(done), 1);
        chk("ign_res", 32'(res_a()), 32'(EQ));
        @(posedge clk); #1;
        run(32'hFFFFFFFF, 32'h0, 1'b0, m, bc, r);
        chk("after_ign_res", 32'(r), 32'(GT));
        chk("after_ign_lat", 32'(m), 1);

        // abort mid-COMP: no done, results cleared
        @(posedge clk);
        @(negedge clk);
        X = 32'h5555AAAA; Y = 32'h5555AAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_res", 32'(res_a()), 32'(R0));
        bc = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) bc++;
        end
        chk("abort_nodone", 32'(bc), 0);

        // abort while in DONE clears the fresh result
        run(32'h80000000, 32'h0, 1'b0, m, bc, r);
        chk("dabort_pre", 32'(r), 32'(GT));
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("dabort_res", 32'(res_a()), 32'(R0));

        // abort outranks start in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("idle_abort", 32'(busy), 0);

        // async reset mid-compare
        run(32'h1, 32'h0, 1'b0, m, bc, r);
        @(negedge clk);
        X = 32'h11111111; Y = 32'h11111111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out", 32'({busy, done, res_a()}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) bc++;
        end
        chk("rst_quiet", 32'(bc), 0);

        // single-slice instance
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            xb = 8'hFF; yb = 8'h01; sgn_b = (k == 0); start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("b%0d_done", k), 32'(done_b), 1);
            chk($sformatf("b%0d_res", k), 32'({gt_b, lt_b, eq_b}),
                32'((k == 0) ? LT : GT));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_serial.md
Name: cmp_serial

Overview:
- Multi-cycle magnitude comparator for wide operands. Compares X and Y one CHUNK-bit slice per cycle, MSB slice first.
- Terminates early at the first differing slice.
- Supports unsigned and two's-complement signed modes, with start/done handshake.
- Feeds the GCD control path when operand width exceeds what a single-cycle compare closes timing at.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. WIDTH must be an integer multiple of CHUNK; otherwise elaboration fails.
- NCHUNK, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; latched on accept
- X  in  WIDTH  operand A; latched on accept
- Y  in  WIDTH  operand B; latched on accept
- busy  out  1  high while in COMP
- done  out  1  one-cycle pulse, high while in DONE
- eq_out  out  1  X == Y
- lt_out  out  1  X < Y
- gt_out  out  1  X > Y

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; busy, done, eq_out, lt_out, gt_out = 0.
  - Operand registers and slice index = 0.
- States: IDLE, COMP, DONE.
- IDLE:
  - start=1 at an edge: latch X, Y, signed_mode; idx=NCHUNK-1; clear eq/lt/gt to 0; go to COMP.
  - start=0: hold results.
- COMP, each edge compares slice idx of latched X vs Y:
  - Slices differ: set lt_out or gt_out per that slice; go to DONE.
  - Slices equal and idx>0: idx decrements; stay in COMP.
  - Slices equal and idx==0: set eq_out; go to DONE.
- Signed mode: MSB of the top slice inverted on both operands before compare (offset-binary). Lower slices are always unsigned.
- DONE: lasts exactly one cycle, then goes to IDLE. done=1 only in DONE.
- Latency:
  - Start accepted at edge E0.
  - Result registers and done valid after edge E0+m, where m = slices examined (1..NCHUNK).
  - Back in IDLE after E0+m+1.
  - Worst case (equal operands) is NCHUNK+1 edges from accept to IDLE.
- Result outputs:
  - Registered and held after DONE until the next accepted start.
  - At most one of eq/lt/gt is high; exactly one after the first completed compare.
- start while in COMP or DONE: ignored; operands not re-latched.
- abort:
  - In COMP or DONE: go to IDLE; eq/lt/gt cleared to 0; done not asserted (abort has priority over a decision in the same cycle).
  - In IDLE: ignored, and has priority over a simultaneous start (no accept).
- rst_n asserted mid-operation: immediate return to reset values. No done is issued for the interrupted compare.
- CHUNK==WIDTH: single-slice compare; m=1 always.
- Index counter width: max(1, $clog2(NCHUNK)).

Decomposition:
- Shared package: state encoding (IDLE, COMP, DONE) and the result one-hot encoding (EQ/LT/GT bit positions). The GCD controller reuses both.
- One sub-module, cmp_slice:
  - Combinational CHUNK-wide eq/lt/gt.
  - Takes a flip_msb input for the signed top slice.
- The FSM, index counter and slice multiplexing stay in cmp_serial.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. Equal operands: X=Y=0x12345678, unsigned, start at E0 -> busy for 4 cycles; done and eq_out=1 after E0+4; idle after E0+5; results held afterwards.
2. Mode check: X=0x80000000, Y=0x7FFFFFFF.
   - Unsigned -> gt_out=1, done after E0+1.
   - Repeat signed -> lt_out=1, done after E0+1.
3. LSB-slice difference: X=0x000000FE, Y=0x000000FF, unsigned -> lt_out=1 after E0+4; all earlier slices report equal.
4. Start while busy: X=Y=0xAAAAAAAA; at E0+2 pulse start with X=0xFFFFFFFF, Y=0 -> ignored; eq_out=1 at E0+4. A new start in IDLE is then accepted normally.
5. Interruptions:
   - abort at E0+2 during an equal-operand compare -> IDLE next edge, eq/lt/gt=0, no done pulse.
   - Separately, rst_n low mid-COMP -> all outputs 0 immediately.
6. Single-slice config (WIDTH=CHUNK=8): X=0xFF, Y=0x01.
   - Signed -> lt_out=1, done after E0+1.
   - Unsigned -> gt_out=1.
